// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared constants, FSM state type and helper function for the
//            8-way priority arbiter (prio_arbiter_8) and its picker.
// Contents : NREQ  - number of requesters
//            ID_W  - width of a requester index
//            arb_state_e - IDLE / BUSY
//            bit_reverse() - mirrors a request vector
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ = 8;
    localparam int ID_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Mirroring the vector turns a "highest index wins" search into a
    // "lowest index wins" search, so one upward-searching picker serves both
    // fixed-priority and round-robin builds.
    function automatic logic [NREQ-1:0] bit_reverse(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = v[NREQ-1-i];
        end
        return r;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/prio_pick8.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick8
// Purpose  : Combinational 8-way picker. Returns the first asserted request
//            found searching upward from i_start, wrapping from 7 to 0.
// Ports    : i_req_masked [7:0] - candidate requests
//            i_start      [2:0] - index searched first
//            o_found            - any candidate asserted
//            o_idx        [2:0] - index of the chosen candidate (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module prio_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req_masked,
    input  logic [ID_W-1:0] i_start,
    output logic            o_found,
    output logic [ID_W-1:0] o_idx
);

    logic [NREQ-1:0] w_rot;
    logic [ID_W-1:0] w_off;

    always_comb begin
        // Rotate so that bit 0 of w_rot is requester i_start.
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = i_req_masked[ID_W'(i) + i_start];
        end

        // Lowest set bit of the rotated vector = first hit searching upward.
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
    end

    assign o_found = |i_req_masked;
    assign o_idx   = o_found ? (i_start + w_off) : '0;

endmodule : prio_pick8
`default_nettype wire

// File: rtl/prio_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : prio_arbiter_8
// Purpose  : 8-requester arbiter with registered one-hot grant and an optional
//            per-holder hold limit. A holder keeps the grant until it drops
//            its request or has held for MAX_HOLD cycles; on release the
//            remaining requests are arbitrated in the same cycle (no bubble).
// Config   : ARB_ROUND_ROBIN_EN defined   -> round-robin from last holder+1
//            ARB_ROUND_ROBIN_EN undefined -> fixed priority, bit 7 highest
// Params   : MAX_HOLD - max consecutive grant cycles per holder, 0 = unlimited
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            req   [7:0]  - request per requester
//            grant [7:0]  - one-hot grant, zero when idle
//            grant_id [2:0] - index of current holder, 0 when idle
//            grant_valid  - a grant is held
//            preempt      - one-cycle pulse after a hold-limit release
// Revision : 1.0 - initial release
// ============================================================================
module prio_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid,
    output logic            preempt
);

    // A zero limit still needs a 1-bit counter to keep widths legal.
    localparam int              HC_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HC_LIMIT = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HC_SAT   = '1;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            preempt_q, preempt_d;

    logic            w_holder_req;
    logic            w_limit_hit;
    logic [NREQ-1:0] w_holder_mask;
    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_pick_req;
    logic [ID_W-1:0] w_pick_start;
    logic            w_found;
    logic [ID_W-1:0] w_pick_idx;
    logic [ID_W-1:0] w_winner;
    logic            w_arbitrate;

    // ------------------------------------------------------------------
    // Eligible set: a holder forced off by the limit sits out the
    // arbitration that removes it; a holder that released has its bit low
    // already.
    // ------------------------------------------------------------------
    always_comb begin
        w_holder_req  = req[grant_id_q];
        w_limit_hit   = (state_q == BUSY) && w_holder_req &&
                        (MAX_HOLD != 0) && (hold_cnt_q == HC_LIMIT);
        w_holder_mask = NREQ'(1) << grant_id_q;
        w_eligible    = w_limit_hit ? (req & ~w_holder_mask) : req;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign w_pick_req   = w_eligible;
    assign w_pick_start = rr_ptr_q + ID_W'(1);
    assign w_winner     = w_pick_idx;
`else
    // Fixed priority: search the mirrored vector from 0, then mirror the
    // index back (7 - idx is a bitwise invert for a 3-bit index).
    assign w_pick_req   = bit_reverse(w_eligible);
    assign w_pick_start = '0;
    assign w_winner     = ~w_pick_idx;
`endif

    prio_pick8 u_pick (
        .i_req_masked (w_pick_req),
        .i_start      (w_pick_start),
        .o_found      (w_found),
        .o_idx        (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
        w_arbitrate = 1'b0;

        case (state_q)
            IDLE: begin
                w_arbitrate = 1'b1;
            end
            BUSY: begin
                if (!w_holder_req || w_limit_hit) begin
                    w_arbitrate = 1'b1;
                end else if (hold_cnt_q != HC_SAT) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                w_arbitrate = 1'b1;
            end
        endcase

        if (w_arbitrate) begin
            preempt_d = w_limit_hit;
            if (w_found) begin
                state_d    = BUSY;
                grant_d    = NREQ'(1) << w_winner;
                grant_id_d = w_winner;
                hold_cnt_d = HC_W'(1);
            end else begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_cnt_d = '0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_arbitrate && w_found) begin
            rr_ptr_d = w_winner;
        end
    end

    // Reset value 7 makes requester 0 the first searched after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= ID_W'(NREQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = (state_q == BUSY);
    assign preempt     = preempt_q;

endmodule : prio_arbiter_8
`default_nettype wire
